sqrt2_host: RTL and testbench
=============================

Name: sqrt2_host

Overview:
Bus-side initiator for the sqrt2 FP16 square-root unit. Accepts FP16 operands on a valid/ready request port and drives them onto the shared tri-state IO_DATA bus with ENABLE. It then releases the bus, waits for RESULT, and captures the result word and the IS_NAN/IS_PINF/IS_NINF flags. The captured result is returned on a valid/ready response port. The block sits between system logic and a sqrt2 instance, and at most one operation is outstanding at a time.

Parameters:
DRIVE_CYCLES, 2, cycles the operand is driven on IO_DATA with ENABLE high before the bus is released (minimum 1)
GAP_CYCLES, 2, cycles ENABLE is held low after an operation, before the next request is accepted (minimum 1)
TIMEOUT_CYCLES, 100, WAIT-state cycle limit (used only with the optional feature)
CNT_W, 8, width of the shared cycle counter; must satisfy 2^CNT_W > max(DRIVE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)

Ports:
CLK  in  1  clock; all logic on the rising edge
RESET  in  1  asynchronous, active-high reset
REQ_VALID  in  1  operand request valid
REQ_READY  out  1  host can accept an operand
REQ_DATA  in  16  FP16 operand
RSP_VALID  out  1  response valid; held until accepted
RSP_READY  in  1  consumer accepts the response
RSP_DATA  out  16  captured FP16 result
RSP_NAN  out  1  captured IS_NAN
RSP_PINF  out  1  captured IS_PINF
RSP_NINF  out  1  captured IS_NINF
RSP_TIMEOUT  out  1  operation aborted by timeout
IO_DATA  inout  16  shared bus to sqrt2
ENABLE  out  1  to sqrt2 ENABLE
RESULT  in  1  from sqrt2 RESULT
IS_NAN, IS_PINF, IS_NINF  in  1 each  from sqrt2

Behaviour:
- Reset values (asynchronous): state IDLE, ENABLE=0, IO_DATA=16'hzzzz, REQ_READY=0 while RESET is high, RSP_VALID=0, RSP_DATA=0, all RSP flags 0, counter 0.
- States: IDLE, DRIVE, WAIT, HOLD, GAP.
- IDLE:
  - REQ_READY = (state==IDLE) && !RSP_VALID; there is no combinational path from RSP_READY.
  - On REQ_VALID&&REQ_READY: latch REQ_DATA into op_q and go to DRIVE.
- DRIVE:
  - ENABLE=1; IO_DATA is driven with op_q, gated by !RESULT, so the host never contends with sqrt2 driving the bus.
  - RESULT is not treated as completion in this state.
  - Stays DRIVE_CYCLES cycles, then goes to WAIT; the bus is Z from the first WAIT cycle.
- WAIT:
  - ENABLE=1, IO_DATA=Z.
  - On a cycle with RESULT=1: register IO_DATA, IS_NAN, IS_PINF and IS_NINF into the RSP_* outputs, set RSP_VALID=1, clear RSP_TIMEOUT, and go to HOLD.
  - Response latency from the REQ handshake to RSP_VALID is DRIVE_CYCLES + 1 + (cycles sqrt2 takes to raise RESULT).
- HOLD: ENABLE=1 for exactly one cycle, then GAP.
- GAP: ENABLE=0 for GAP_CYCLES cycles, then IDLE.
- Response port:
  - RSP_VALID clears on RSP_VALID&&RSP_READY.
  - RSP_* values stay stable while RSP_VALID is high.
  - A response not yet accepted blocks REQ_READY, even when the host is back in IDLE.
- Simultaneous events:
  - RSP accepted in the same cycle the GAP→IDLE transition happens: REQ_READY rises the following cycle.
  - RESULT is sampled only in WAIT.
- Reset mid-operation: ENABLE drops and the bus releases asynchronously; any pending response is discarded.
- The counter is shared by DRIVE, WAIT and GAP and clears on every state change.

Optional Feature:
Macro SQRT2_HOST_TIMEOUT_EN.
- Defined: if WAIT has lasted TIMEOUT_CYCLES cycles without RESULT, the host leaves WAIT and issues a response with RSP_TIMEOUT=1, RSP_DATA=16'h0000 and all flags 0. It then follows HOLD→GAP as normal.
- Undefined: WAIT lasts indefinitely, RSP_TIMEOUT is tied to 0, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package sqrt2_pkg holds:
  - the state enum (IDLE/DRIVE/WAIT/HOLD/GAP);
  - FP16 constants FP16_QNAN=16'hFE00, FP16_PINF=16'h7C00, FP16_NINF=16'hFC00, FP16_PZERO=16'h0000, FP16_NZERO=16'h8000;
  - FP16 width localparam 16.
- No sub-module: the tri-state driver is a single gated assign, and the FSM and counter stay flat.

Test Plan:
- REQ_DATA=16'h4400, RSP_READY=1, real sqrt2 attached → RSP_DATA=16'h4000, all flags 0. IO_DATA driven for exactly 2 cycles with ENABLE=1, then Z.
- Specials, one request each:
  - 16'hFC00 → 16'hFE00 with RSP_NAN=1.
  - 16'h7C00 → 16'h7C00 with RSP_PINF=1.
  - 16'h8000 → 16'h8000 with flags 0.
- Back-to-back 16'h0001 then 16'h7BFF:
  - RSP_READY=0 for 10 cycles after the first response → RSP_VALID and RSP_DATA=16'h0C00 held, REQ_READY=0 throughout.
  - After acceptance, the second response is 16'h5BFF.
  - ENABLE is low for at least 2 cycles between the two operations.
- Stub device holding RESULT=0, with the macro defined → RSP_TIMEOUT=1 and RSP_DATA=16'h0000 exactly 100 WAIT cycles after DRIVE ends. With the macro undefined, RSP_VALID stays 0 for 500 cycles.
- Stub device raising RESULT during DRIVE → IO_DATA from the host released in the same cycle, with no X on the bus.
- RESET pulsed during WAIT of 16'h4880 → ENABLE=0 and IO_DATA=Z immediately, RSP_VALID=0. A subsequent 16'h4880 request returns 16'h4200.

Source files
------------

// File: rtl/sqrt2_pkg.sv
// Shared types and FP16 constants for the sqrt2 host slice.
// Holds the host FSM state enum, the FP16 word width and special encodings.
package sqrt2_pkg;

  localparam int FP16_W = 16;

  localparam logic [FP16_W-1:0] FP16_QNAN  = 16'hFE00;
  localparam logic [FP16_W-1:0] FP16_PINF  = 16'h7C00;
  localparam logic [FP16_W-1:0] FP16_NINF  = 16'hFC00;
  localparam logic [FP16_W-1:0] FP16_PZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_NZERO = 16'h8000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/sqrt2_host.sv
// Bus-side initiator for the sqrt2 FP16 square-root unit.
// Ports: REQ_* operand in (valid/ready), RSP_* result out (valid/ready),
// IO_DATA shared tri-state bus, ENABLE/RESULT/IS_* to and from sqrt2.
// Optional: SQRT2_HOST_TIMEOUT_EN aborts a WAIT after TIMEOUT_CYCLES.
module sqrt2_host
  import sqrt2_pkg::*;
#(
  parameter int DRIVE_CYCLES   = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CNT_W          = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [FP16_W-1:0] REQ_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [FP16_W-1:0] RSP_DATA,
  output logic              RSP_NAN,
  output logic              RSP_PINF,
  output logic              RSP_NINF,
  output logic              RSP_TIMEOUT,
  inout  wire  [FP16_W-1:0] IO_DATA,
  output logic              ENABLE,
  input  logic              RESULT,
  input  logic              IS_NAN,
  input  logic              IS_PINF,
  input  logic              IS_NINF
);

  localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FP16_W-1:0] op_q;
  logic              rsp_vld_q;
  logic [FP16_W-1:0] rsp_data_q;
  logic              rsp_nan_q;
  logic              rsp_pinf_q;
  logic              rsp_ninf_q;
  logic              req_fire;
  logic              rsp_fire;
  logic              cap_res;
`ifdef SQRT2_HOST_TIMEOUT_EN
  logic              cap_to;
  logic              rsp_to_q;
`endif

  assign REQ_READY = (state_q == IDLE) && !rsp_vld_q && !RESET;
  assign req_fire  = REQ_VALID && REQ_READY;
  assign rsp_fire  = rsp_vld_q && RSP_READY;

  assign ENABLE = (state_q == DRIVE) || (state_q == WAIT) ||
                  (state_q == HOLD);

  // Released as soon as sqrt2 claims the bus with RESULT.
  assign IO_DATA = ((state_q == DRIVE) && !RESULT) ? op_q : 'z;

  assign RSP_VALID = rsp_vld_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_NAN   = rsp_nan_q;
  assign RSP_PINF  = rsp_pinf_q;
  assign RSP_NINF  = rsp_ninf_q;
`ifdef SQRT2_HOST_TIMEOUT_EN
  assign RSP_TIMEOUT = rsp_to_q;
`else
  assign RSP_TIMEOUT = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_res = 1'b0;
`ifdef SQRT2_HOST_TIMEOUT_EN
    cap_to  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_fire) state_d = DRIVE;
      end
      DRIVE: begin
        if (cnt_q == DRV_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (RESULT) begin
          cap_res = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
        end
`ifdef SQRT2_HOST_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          cap_to  = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
        end
`endif
        // Saturates so a long wait never wraps the counter.
        else if (cnt_q != TO_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_nan_q  <= 1'b0;
      rsp_pinf_q <= 1'b0;
      rsp_ninf_q <= 1'b0;
`ifdef SQRT2_HOST_TIMEOUT_EN
      rsp_to_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_fire) op_q <= REQ_DATA;
      if (rsp_fire) rsp_vld_q <= 1'b0;
      if (cap_res) begin
        rsp_vld_q  <= 1'b1;
        rsp_data_q <= IO_DATA;
        rsp_nan_q  <= IS_NAN;
        rsp_pinf_q <= IS_PINF;
        rsp_ninf_q <= IS_NINF;
`ifdef SQRT2_HOST_TIMEOUT_EN
        rsp_to_q   <= 1'b0;
`endif
      end
`ifdef SQRT2_HOST_TIMEOUT_EN
      if (cap_to) begin
        rsp_vld_q  <= 1'b1;
        rsp_data_q <= FP16_PZERO;
        rsp_nan_q  <= 1'b0;
        rsp_pinf_q <= 1'b0;
        rsp_ninf_q <= 1'b0;
        rsp_to_q   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sqrt2_host.sv
// Scoreboard bench for sqrt2_host with a behavioural sqrt2 device.
// Device modes: table lookup, never-respond stub, early-RESULT stub.
module tb_sqrt2_host;
  import sqrt2_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic        nan;
    logic        pinf;
    logic        ninf;
    logic        to;
  } exp_t;

  localparam int M_NORM  = 0;
  localparam int M_NEVER = 1;
  localparam int M_EARLY = 2;
  localparam int LAT     = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [15:0] REQ_DATA = 16'h0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b1;
  logic [15:0] RSP_DATA;
  logic        RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT;
  tri1  [15:0] IO_DATA;
  logic        ENABLE;
  logic        RESULT = 1'b0;
  logic        IS_NAN = 1'b0;
  logic        IS_PINF = 1'b0;
  logic        IS_NINF = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  sqrt2_host dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_NAN(RSP_NAN), .RSP_PINF(RSP_PINF), .RSP_NINF(RSP_NINF),
    .RSP_TIMEOUT(RSP_TIMEOUT), .IO_DATA(IO_DATA), .ENABLE(ENABLE),
    .RESULT(RESULT), .IS_NAN(IS_NAN), .IS_PINF(IS_PINF), .IS_NINF(IS_NINF)
  );

  always #5 CLK = ~CLK;

  // Behavioural sqrt2 device.
  int          mode = M_NORM;
  int          dcnt = 0;
  logic        dev_oe = 1'b0;
  logic [15:0] dev_data = 16'h0;
  logic [15:0] dev_op = 16'h0;

  assign IO_DATA = dev_oe ? dev_data : 16'hzzzz;

  function automatic logic [18:0] lut(input logic [15:0] x);
    unique case (x)
      16'h4400: lut = {16'h4000, 3'b000};
      16'hFC00: lut = {16'hFE00, 3'b100};
      16'h7C00: lut = {16'h7C00, 3'b010};
      16'h8000: lut = {16'h8000, 3'b000};
      16'h0001: lut = {16'h0C00, 3'b000};
      16'h7BFF: lut = {16'h5BFF, 3'b000};
      16'h4880: lut = {16'h4200, 3'b000};
      default:  lut = {16'hFE00, 3'b100};
    endcase
  endfunction

  always @(posedge CLK) begin
    if (!ENABLE) begin
      dcnt    <= 0;
      dev_oe  <= 1'b0;
      RESULT  <= 1'b0;
      IS_NAN  <= 1'b0;
      IS_PINF <= 1'b0;
      IS_NINF <= 1'b0;
    end else begin
      dcnt <= dcnt + 1;
      if (dcnt == 0) dev_op <= IO_DATA;
      if (mode == M_NORM && dcnt == LAT) begin
        {dev_data, IS_NAN, IS_PINF, IS_NINF} <= lut(dev_op);
        dev_oe <= 1'b1;
        RESULT <= 1'b1;
      end
      if (mode == M_EARLY && dcnt == 0) begin
        dev_data <= 16'h1234;
        dev_oe   <= 1'b1;
        RESULT   <= 1'b1;
      end
    end
  end

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: pop and compare on every accepted response.
  always @(negedge CLK) begin
    if (!RESET && RSP_VALID && RSP_READY) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_rsp", {12'h0, RSP_DATA, 4'h0}, 32'h0);
      end else begin
        exp_t e;
        exp_t a;
        e = sb.pop_front();
        a = {RSP_DATA, RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT};
        chk(a == e, "rsp", 32'(a), 32'(e));
      end
    end
  end

  // ENABLE must stay low at least GAP_CYCLES between operations.
  int lowrun = 0;
  bit seen = 1'b0;
  bit prev_en = 1'b0;
  always @(negedge CLK) begin
    if (RESET) begin
      lowrun  = 0;
      seen    = 1'b0;
      prev_en = 1'b0;
    end else if (ENABLE) begin
      if (!prev_en && seen)
        chk(lowrun >= 2, "enable_gap", 32'(lowrun), 32'd2);
      seen    = 1'b1;
      lowrun  = 0;
      prev_en = 1'b1;
    end else begin
      lowrun++;
      prev_en = 1'b0;
    end
  end

  // Bus observer for the operand-drive window.
  bit          trk = 1'b0;
  logic [15:0] trk_op = 16'h0;
  int          drv_n = 0;
  int          bus_bad = 0;
  always @(negedge CLK) begin
    if (trk && ENABLE && !RESULT) begin
      if (IO_DATA == trk_op) drv_n++;
      else if (IO_DATA != 16'hFFFF) bus_bad++;
    end
  end

  task automatic send(input logic [15:0] op);
    int n;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) chk(1'b0, "req_ready_wait", 32'h0, 32'h1);
    REQ_VALID = 1'b1;
    REQ_DATA  = op;
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0)
      chk(1'b0, "rsp_wait", 32'(sb.size()), 32'h0);
    repeat (5) @(negedge CLK);
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic [2:0] f);
    return {d, f, 1'b0};
  endfunction

  initial begin
    int n;
    int hits;
    bit ok;

    // Reset state.
    repeat (2) @(negedge CLK);
    chk(REQ_READY == 1'b0, "rst_req_ready", 32'(REQ_READY), 32'h0);
    chk(ENABLE == 1'b0, "rst_enable", 32'(ENABLE), 32'h0);
    chk(RSP_VALID == 1'b0, "rst_rsp_valid", 32'(RSP_VALID), 32'h0);
    chk({RSP_DATA, RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT} == 20'h0,
        "rst_rsp", 32'(RSP_DATA), 32'h0);
    chk(IO_DATA == 16'hFFFF, "rst_bus", 32'(IO_DATA), 32'hFFFF);
    RESET = 1'b0;
    @(negedge CLK);
    chk(REQ_READY == 1'b1, "idle_req_ready", 32'(REQ_READY), 32'h1);

    // Basic operation and drive window.
    trk = 1'b1;
    trk_op = 16'h4400;
    drv_n = 0;
    bus_bad = 0;
    sb.push_back(mk(16'h4000, 3'b000));
    send(16'h4400);
    drain();
    trk = 1'b0;
    chk(drv_n == 2, "drive_cycles", 32'(drv_n), 32'd2);
    chk(bus_bad == 0, "bus_released", 32'(bus_bad), 32'd0);

    // Specials.
    sb.push_back(mk(FP16_QNAN, 3'b100));
    send(FP16_NINF);
    drain();
    sb.push_back(mk(FP16_PINF, 3'b010));
    send(FP16_PINF);
    drain();
    sb.push_back(mk(FP16_NZERO, 3'b000));
    send(FP16_NZERO);
    drain();

    // Back-to-back with a stalled consumer.
    RSP_READY = 1'b0;
    sb.push_back(mk(16'h0C00, 3'b000));
    send(16'h0001);
    n = 0;
    while (!RSP_VALID && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk(RSP_VALID == 1'b1, "stall_rsp_seen", 32'(RSP_VALID), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      ok = RSP_VALID && (RSP_DATA == 16'h0C00) && !REQ_READY;
      chk(ok, "stall_hold", {RSP_VALID, REQ_READY, 14'h0, RSP_DATA},
          {2'b10, 14'h0, 16'h0C00});
    end
    RSP_READY = 1'b1;
    sb.push_back(mk(16'h5BFF, 3'b000));
    send(16'h7BFF);
    drain();

    // Device that never answers.
    mode = M_NEVER;
`ifdef SQRT2_HOST_TIMEOUT_EN
    sb.push_back({16'h0000, 3'b000, 1'b1});
    send(16'h4400);
    n = 0;
    while (!RSP_VALID && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk(n == 102, "timeout_latency", 32'(n), 32'd102);
    drain();
`else
    send(16'h4400);
    hits = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (RSP_VALID) hits++;
    end
    chk(hits == 0, "no_timeout", 32'(hits), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
`endif

    // Device raising RESULT during DRIVE.
    mode = M_EARLY;
    sb.push_back(mk(16'h1234, 3'b000));
    send(16'h4400);
    @(negedge CLK);
    chk(RESULT && IO_DATA == 16'h1234, "early_bus",
        {15'h0, RESULT, IO_DATA}, {15'h0, 1'b1, 16'h1234});
    drain();

    // Reset during WAIT.
    mode = M_NORM;
    send(16'h4880);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk(ENABLE == 1'b0, "midrst_enable", 32'(ENABLE), 32'h0);
    chk(IO_DATA == 16'hFFFF, "midrst_bus", 32'(IO_DATA), 32'hFFFF);
    chk(RSP_VALID == 1'b0, "midrst_rsp", 32'(RSP_VALID), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    sb.push_back(mk(16'h4200, 3'b000));
    send(16'h4880);
    drain();

    chk(sb.size() == 0, "sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

endmodule
